uart1_rx: RTL and testbench

Serial receiver that sits directly downstream of the UART1 transmitter and consumes its serial line. It oversamples `serial_in` with a fixed clocks-per-bit count and recovers 8-bit frames: start, 8 data bits LSB first, parity, stop. For each frame it presents the byte with a one-cycle valid pulse plus parity and framing error flags. It closes the loopback path so TX-side data can be checked end to end.

---
 rtl/uart1_pkg.sv | 28 ++
 rtl/uart1_sync2.sv | 25 ++
 rtl/uart1_rx.sv | 157 +++++++++++++++
 tb/tb_uart1_rx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart1_pkg.sv
// uart1_pkg: definitions shared by the UART1 transmitter and receiver.
//   - FSM state encodings (3 bits)
//   - DATA_BITS: payload width of one frame
//   - parity mode constants and a parity helper
package uart1_pkg;

  localparam int DATA_BITS = 8;

  // Parity mode selectors, used for the PARITY_ODD parameter on both sides.
  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  // Receiver FSM state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  // Parity bit the transmitter puts on the line for data d.
  // odd = 0 gives even parity (^d), odd = 1 gives odd parity.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d,
                                       input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart1_sync2.sv
// uart1_sync2: two-flop synchronizer for an asynchronous serial line.
//   clk  in  : sampling clock
//   rst  in  : asynchronous active-low reset; both flops reset to 1 (line idle)
//   d    in  : asynchronous input
//   q    out : synchronized output
module uart1_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart1_rx.sv
// uart1_rx: UART1 serial receiver (start, 8 data bits LSB first, parity, stop).
//   clk        in  : clock, all state on rising edge
//   rst        in  : asynchronous active-low reset
//   serial_in  in  : serial line, idle high, asynchronous to clk
//   rx_data    out : last received byte, held until the next frame completes
//   rx_valid   out : one-cycle pulse when a frame completes
//   parity_err out : with rx_valid, received parity did not match
//   frame_err  out : with rx_valid, stop bit sampled low
//   busy       out : high in every state except IDLE
//   state_dbg  out : current FSM state (uart1_pkg ST_* encoding)
//
// Handshake: rx_valid is a bare one-cycle valid pulse with no ready; rx_data,
// parity_err and frame_err change only in the rx_valid cycle and hold after it.
module uart1_rx
  import uart1_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy,
  output logic [2:0]           state_dbg
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);
  localparam logic          ODD_BIT  = (PARITY_ODD != 0);

  logic                 line;
  logic                 line_q;     // previous synchronized sample, for edge detect
  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_q;
  logic                 stop_bit;
  logic                 stop_seen;  // stop sampled; outputs load on the next edge

  uart1_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (serial_in),
    .q   (line)
  );

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q     <= 1'b1;
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      perr_q     <= 1'b0;
      stop_bit   <= 1'b0;
      stop_seen  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      line_q   <= line;
      rx_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (line_q && !line) begin
            cnt   <= '0;
            state <= ST_START;
          end
        end

        // Re-check the line at mid start bit; a high sample was a glitch.
        ST_START: begin
          if (cnt == CNT_HALF) begin
            if (line) begin
              state <= ST_IDLE;
            end else begin
              cnt     <= '0;
              bit_idx <= '0;
              state   <= ST_DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // From here every sample lands one full bit later, i.e. mid-bit.
        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            shreg[bit_idx] <= line;
            cnt            <= '0;
            if (bit_idx == IDX_LAST) begin
              state <= ST_PARITY;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_PARITY: begin
          if (cnt == CNT_LAST) begin
            perr_q <= line ^ calc_parity(shreg, ODD_BIT);
            cnt    <= '0;
            state  <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Leaves at mid stop bit so a following start edge is never missed.
        ST_STOP: begin
          if (!stop_seen) begin
            if (cnt == CNT_LAST) begin
              stop_bit  <= line;
              stop_seen <= 1'b1;
              cnt       <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            rx_data    <= shreg;
            parity_err <= perr_q;
            frame_err  <= ~stop_bit;
            rx_valid   <= 1'b1;
            stop_seen  <= 1'b0;
            state      <= stop_bit ? ST_IDLE : ST_BREAK;
          end
        end

        // Line held low past the stop bit: wait for it to return to idle.
        ST_BREAK: begin
          if (line) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart1_rx.sv
// tb_uart1_rx: directed testbench for uart1_rx at CLKS_PER_BIT = 16, even parity.
module tb_uart1_rx;

  localparam int C = 16;
  localparam int W = 10;  // scoreboard word: {frame_err, parity_err, rx_data}

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       serial_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  uart1_rx #(
    .CLKS_PER_BIT (C),
    .PARITY_ODD   (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           vcyc_q[$];
  int           pulses   = 0;
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] mon_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid) begin
      pulses++;
      vcyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rx_word", {22'd0, frame_err, parity_err, rx_data}, {22'd0, mon_exp});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic send_bit(input logic b);
    serial_in = b;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // t0 is the cycle of the first clock edge that samples the start bit.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            output int t0);
    t0 = cyc + 1;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
  endtask

  int p0;
  int n0;
  int t0;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_data", {24'd0, rx_data}, 32'h00);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, 32'd0);
    rst = 1'b1;
    idle(4);

    // 1: 0xA5, even parity bit 0, latency 2 + 8 + 160 + 1 = 171
    p0 = pulses; n0 = vcyc_q.size();
    exp_q.push_back({2'b00, 8'hA5});
    send_frame(8'hA5, 1'b0, 1'b1, t0);
    idle(C);
    check("t1_pulses", pulses - p0, 32'd1);
    check("t1_latency", (vcyc_q.size() > n0) ? vcyc_q[n0] - t0 : -1, 32'd171);
    check("t1_hold_data", {24'd0, rx_data}, 32'hA5);

    // 2: 0x07 with correct parity 1, then with wrong parity 0
    p0 = pulses;
    exp_q.push_back({2'b00, 8'h07});
    send_frame(8'h07, 1'b1, 1'b1, t0);
    idle(C);
    check("t2_good_perr", {31'd0, parity_err}, 32'd0);
    exp_q.push_back({2'b01, 8'h07});
    send_frame(8'h07, 1'b0, 1'b1, t0);
    idle(C);
    check("t2_pulses", pulses - p0, 32'd2);
    check("t2_hold_perr", {31'd0, parity_err}, 32'd1);

    // 3: 4-cycle low glitch, busy must be back to 0 within 12 cycles
    p0 = pulses;
    serial_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    serial_in = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("t3_busy", {31'd0, busy}, 32'd0);
    idle(2 * C);
    check("t3_pulses", pulses - p0, 32'd0);

    // 4: 0x3C with low stop bit, 40 bits of break, then clean 0x55
    p0 = pulses;
    exp_q.push_back({2'b10, 8'h3C});
    send_frame(8'h3C, 1'b0, 1'b0, t0);
    for (int i = 0; i < 40; i++) send_bit(1'b0);
    check("t4_break_pulses", pulses - p0, 32'd1);
    check("t4_break_busy", {31'd0, busy}, 32'd1);
    check("t4_break_state", {29'd0, state_dbg}, 32'd5);
    check("t4_hold_ferr", {31'd0, frame_err}, 32'd1);
    send_bit(1'b1);
    exp_q.push_back({2'b00, 8'h55});
    send_frame(8'h55, 1'b0, 1'b1, t0);
    idle(C);
    check("t4_pulses", pulses - p0, 32'd2);
    check("t4_clean_ferr", {31'd0, frame_err}, 32'd0);

    // 5: back-to-back, zero idle bits
    p0 = pulses; n0 = vcyc_q.size();
    exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b00, 8'hFF});
    exp_q.push_back({2'b00, 8'h81});
    send_frame(8'h00, 1'b0, 1'b1, t0);
    send_frame(8'hFF, 1'b0, 1'b1, t0);
    send_frame(8'h81, 1'b0, 1'b1, t0);
    idle(C);
    check("t5_pulses", pulses - p0, 32'd3);
    check("t5_gap1", (vcyc_q.size() > n0 + 1) ? vcyc_q[n0+1] - vcyc_q[n0] : -1, 32'd176);
    check("t5_gap2", (vcyc_q.size() > n0 + 2) ? vcyc_q[n0+2] - vcyc_q[n0+1] : -1, 32'd176);

    // 6: reset during data bit 3 of 0x5A, then a full 0x5A
    p0 = pulses;
    send_bit(1'b0);  // start
    send_bit(1'b0);  // d0
    send_bit(1'b1);  // d1
    send_bit(1'b0);  // d2
    serial_in = 1'b1; // d3
    repeat (C / 2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("t6_rst_rx_data", {24'd0, rx_data}, 32'h00);
    check("t6_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("t6_rst_perr", {31'd0, parity_err}, 32'd0);
    check("t6_rst_ferr", {31'd0, frame_err}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    serial_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2 * C);
    check("t6_no_partial", pulses - p0, 32'd0);
    exp_q.push_back({2'b00, 8'h5A});
    send_frame(8'h5A, 1'b0, 1'b1, t0);
    idle(C);
    check("t6_pulses", pulses - p0, 32'd1);
    check("t6_hold_data", {24'd0, rx_data}, 32'h5A);

    // ---------------- final report ----------------
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
